// File: rtl/nvram_pkg.sv
// Shared types and helpers for the NVRAM save/restore bridge.
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        RD,
        WR
    } nv_state_t;

    localparam logic [15:0] NV_INDEX_DEF = 16'd4;

    function automatic logic [7:0] nv_din_pad(input logic [7:0] q,
                                              input int unsigned w);
        return q & (8'hFF >> (8 - w));
    endfunction

endpackage

// File: rtl/nvram_io.sv
// ioctl <-> battery-backed CMOS RAM bridge: upload/download of NVRAM
// through hps_io, arbitrating for the RAM port against the CPU.
module nvram_io
    import nvram_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 4,
    parameter logic [15:0] NV_INDEX = NV_INDEX_DEF,
    parameter int          RD_LAT   = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic [15:0]       ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              nv_req,
    input  logic              nv_gnt,
    output logic [ADDR_W-1:0] nv_addr,
    input  logic [DATA_W-1:0] nv_q,
    output logic [DATA_W-1:0] nv_d,
    output logic              nv_we,
    input  logic              cpu_nv_we,
    output logic              nv_dirty
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    nv_state_t   state, state_n;
    logic [1:0]  lat_cnt;
    logic        op_rd;
    logic        sess, sess_q, up_q, last_done;
    logic        idx_ok, in_rng;
    logic        rd_acc, wr_acc, rd_cap, sess_end, clr;

    assign idx_ok = (ioctl_index == NV_INDEX);
    assign sess   = (ioctl_upload | ioctl_download) & idx_ok;
    assign in_rng = ((ioctl_addr >> ADDR_W) == 25'd0);

    // Strobes are only taken while idle; anything during a stall is dropped.
    assign rd_acc = reset_n & ioctl_rd & ioctl_upload & idx_ok &
                    (state == IDLE);
    assign wr_acc = reset_n & ioctl_wr & ioctl_download & idx_ok &
                    (state == IDLE) & ~rd_acc;

    assign ioctl_wait = rd_acc | wr_acc | (state != IDLE);
    assign nv_we      = (state == WR) & nv_gnt;

    assign sess_end = sess_q & ~sess;
    assign clr      = sess_end & (~up_q | last_done);

    always_comb begin
        state_n = state;
        rd_cap  = 1'b0;
        unique case (state)
            IDLE: begin
                if ((rd_acc | wr_acc) & in_rng) begin
                    if (!nv_gnt)
                        state_n = WAIT_GNT;
                    else if (rd_acc)
                        state_n = RD;
                    else
                        state_n = WR;
                end
            end
            WAIT_GNT: begin
                if (nv_gnt)
                    state_n = op_rd ? RD : WR;
            end
            RD: begin
                if (!nv_gnt) begin
                    state_n = WAIT_GNT;
                end else if (lat_cnt == LAT_LAST) begin
                    rd_cap  = 1'b1;
                    state_n = IDLE;
                end
            end
            WR: begin
                state_n = nv_gnt ? IDLE : WAIT_GNT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_cnt   <= 2'd0;
            op_rd     <= 1'b0;
            sess_q    <= 1'b0;
            up_q      <= 1'b0;
            last_done <= 1'b0;
            nv_req    <= 1'b0;
            nv_addr   <= '0;
            nv_d      <= '0;
            ioctl_din <= 8'h00;
            nv_dirty  <= 1'b0;
        end else begin
            state  <= state_n;
            sess_q <= sess;
            // Hold the port until an in-flight access drains.
            nv_req <= sess | (state_n != IDLE);

            if (sess)
                up_q <= ioctl_upload;

            if (rd_acc | wr_acc) begin
                op_rd <= rd_acc;
                if (in_rng)
                    nv_addr <= ADDR_W'(ioctl_addr);
                if (wr_acc & in_rng)
                    nv_d <= DATA_W'(ioctl_dout);
            end

            if (state == RD)
                lat_cnt <= lat_cnt + 2'd1;
            else
                lat_cnt <= 2'd0;

            if (rd_acc & ~in_rng)
                ioctl_din <= 8'h00;
            else if (rd_cap)
                ioctl_din <= nv_din_pad(8'(nv_q), DATA_W);

            if (rd_cap && nv_addr == {ADDR_W{1'b1}})
                last_done <= 1'b1;
            else if (sess_end)
                last_done <= 1'b0;

            // A CPU write in the clearing cycle must not be lost.
            if (cpu_nv_we)
                nv_dirty <= 1'b1;
            else if (clr)
                nv_dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nvram_io.sv
// Scoreboard bench for nvram_io: RAM model, queued expectations,
// timing spot checks and dirty-flag sequences.
module tb_nvram_io;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [15:0] ioctl_index = 16'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic        ioctl_rd = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        nv_req;
    logic        nv_gnt = 1'b1;
    logic [9:0]  nv_addr;
    logic [3:0]  nv_q;
    logic [3:0]  nv_d;
    logic        nv_we;
    logic        cpu_nv_we = 1'b0;
    logic        nv_dirty;

    always #5 clk_sys = ~clk_sys;

    nvram_io dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_upload   (ioctl_upload),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .nv_req         (nv_req),
        .nv_gnt         (nv_gnt),
        .nv_addr        (nv_addr),
        .nv_q           (nv_q),
        .nv_d           (nv_d),
        .nv_we          (nv_we),
        .cpu_nv_we      (cpu_nv_we),
        .nv_dirty       (nv_dirty)
    );

    // RAM model: unwritten locations read a fixed pattern.
    logic [3:0] ram [1024];
    bit         ram_v [1024];

    function automatic logic [3:0] init_val(input int a);
        if (a == 5)
            return 4'hA;
        return 4'(a * 7 + 3);
    endfunction

    function automatic logic [3:0] mem_rd(input int a);
        return ram_v[a] ? ram[a] : init_val(a);
    endfunction

    assign nv_q = mem_rd(int'(nv_addr));

    always @(posedge clk_sys) begin
        if (nv_we) begin
            ram[nv_addr]   <= nv_d;
            ram_v[nv_addr] <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit         rd;
        logic [9:0] addr;
        logic [7:0] dat;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    logic prev_wait = 1'b0;
    int   we_cnt = 0;

    always @(negedge clk_sys) begin
        if (nv_we) begin
            we_cnt++;
            if (sb.size() == 0 || sb[0].rd) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("we_addr", 32'(nv_addr), 32'(mon_e.addr));
                check("we_data", 32'(nv_d), 32'(mon_e.dat));
            end
        end
        if (prev_wait && !ioctl_wait && sb.size() > 0 && sb[0].rd) begin
            mon_e = sb.pop_front();
            check("rd_din", 32'(ioctl_din), 32'(mon_e.dat));
        end
        prev_wait = ioctl_wait;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_sys);
        while (ioctl_wait && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait)
            check("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic rd_op(input logic [24:0] a, input bit push);
        sb_t e;
        if (push) begin
            e.rd   = 1'b1;
            e.addr = a[9:0];
            e.dat  = (a < 25'd1024) ? {4'h0, mem_rd(int'(a))} : 8'h00;
            sb.push_back(e);
        end
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b0;
        wait_idle();
    endtask

    task automatic wr_op(input logic [24:0] a, input logic [7:0] d,
                         input bit push);
        sb_t e;
        if (push) begin
            e.rd   = 1'b0;
            e.addr = a[9:0];
            e.dat  = {4'h0, d[3:0]};
            sb.push_back(e);
        end
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b0;
        wait_idle();
    endtask

    task automatic end_session(input bit cpu_we);
        @(posedge clk_sys); #1;
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
        cpu_nv_we      = cpu_we;
        @(posedge clk_sys); #1;
        cpu_nv_we      = 1'b0;
    endtask

    task automatic cpu_pulse();
        @(posedge clk_sys); #1;
        cpu_nv_we = 1'b1;
        @(posedge clk_sys); #1;
        cpu_nv_we = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        sb_t e;

        // Reset values
        repeat (3) @(negedge clk_sys);
        check("rst_din", 32'(ioctl_din), 32'h00);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_req", 32'(nv_req), 32'd0);
        check("rst_addr", 32'(nv_addr), 32'd0);
        check("rst_d", 32'(nv_d), 32'd0);
        check("rst_we", 32'(nv_we), 32'd0);
        check("rst_dirty", 32'(nv_dirty), 32'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;

        // Upload read with grant held, timed
        ioctl_index  = 16'd4;
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("req_up", 32'(nv_req), 32'd1);
        e.rd = 1'b1; e.addr = 10'd5; e.dat = 8'h0A;
        sb.push_back(e);
        @(posedge clk_sys); #1;
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        check("rd_wait_T", 32'(ioctl_wait), 32'd1);
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        check("rd_addr_T1", 32'(nv_addr), 32'd5);
        check("rd_wait_T1", 32'(ioctl_wait), 32'd1);
        @(negedge clk_sys);
        check("rd_din_T2", 32'(ioctl_din), 32'h0A);
        check("rd_wait_T2", 32'(ioctl_wait), 32'd0);

        // Filtered: write strobe during upload
        w0 = we_cnt;
        @(posedge clk_sys); #1;
        ioctl_addr = 25'd6;
        ioctl_dout = 8'h55;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        check("wr_in_up_wait", 32'(ioctl_wait), 32'd0);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("wr_in_up_we", 32'(we_cnt), 32'(w0));

        // Out-of-range read returns zero one cycle after the strobe
        e.rd = 1'b1; e.addr = 10'd0; e.dat = 8'h00;
        sb.push_back(e);
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h400;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        check("oor_wait_T", 32'(ioctl_wait), 32'd1);
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        check("oor_din", 32'(ioctl_din), 32'h00);
        check("oor_wait_T1", 32'(ioctl_wait), 32'd0);

        // Wrong index: no session, strobe ignored
        rd_op(25'd5, 1'b0);
        ioctl_index = 16'd3;
        repeat (2) @(negedge clk_sys);
        check("idx3_req", 32'(nv_req), 32'd0);
        @(posedge clk_sys); #1;
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        check("idx3_wait", 32'(ioctl_wait), 32'd0);
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("idx3_din", 32'(ioctl_din), 32'h0A);
        ioctl_index = 16'd4;
        end_session(1'b0);
        @(negedge clk_sys);
        check("req_drop", 32'(nv_req), 32'd0);

        // Download: timed write at the top address
        cpu_pulse();
        @(negedge clk_sys);
        check("dirty_set", 32'(nv_dirty), 32'd1);
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        e.rd = 1'b0; e.addr = 10'h3FF; e.dat = 8'h07;
        sb.push_back(e);
        w0 = we_cnt;
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h3FF;
        ioctl_dout = 8'hF7;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        check("wr_we_T", 32'(nv_we), 32'd0);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("wr_we_T1", 32'(nv_we), 32'd1);
        check("wr_addr_T1", 32'(nv_addr), 32'h3FF);
        check("wr_d_T1", 32'(nv_d), 32'h7);
        @(negedge clk_sys);
        check("wr_we_T2", 32'(nv_we), 32'd0);
        check("wr_wait_T2", 32'(ioctl_wait), 32'd0);
        check("wr_pulses", 32'(we_cnt), 32'(w0 + 1));

        // Out-of-range write dropped
        w0 = we_cnt;
        wr_op(25'h400, 8'h33, 1'b0);
        repeat (2) @(negedge clk_sys);
        check("oor_wr_we", 32'(we_cnt), 32'(w0));

        // Late grant on a write
        nv_gnt = 1'b0;
        w0 = we_cnt;
        e.rd = 1'b0; e.addr = 10'h010; e.dat = 8'h0C;
        sb.push_back(e);
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h010;
        ioctl_dout = 8'h3C;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("lg_wr_wait", 32'(ioctl_wait), 32'd1);
        check("lg_wr_nowe", 32'(we_cnt), 32'(w0));
        @(posedge clk_sys); #1;
        nv_gnt = 1'b1;
        wait_idle();
        check("lg_wr_we", 32'(we_cnt), 32'(w0 + 1));

        end_session(1'b0);
        @(negedge clk_sys);
        check("dl_clears_dirty", 32'(nv_dirty), 32'd0);

        // Upload: read back written data, then late grant read
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        rd_op(25'h3FF, 1'b1);
        rd_op(25'h010, 1'b1);
        nv_gnt = 1'b0;
        e.rd = 1'b1; e.addr = 10'd7; e.dat = {4'h0, init_val(7)};
        sb.push_back(e);
        w0 = we_cnt;
        @(posedge clk_sys); #1;
        ioctl_addr = 25'd7;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            check("lg_rd_wait", 32'(ioctl_wait), 32'd1);
        end
        @(posedge clk_sys); #1;
        nv_gnt = 1'b1;
        @(negedge clk_sys);
        check("lg_rd_wait_G", 32'(ioctl_wait), 32'd1);
        @(negedge clk_sys);
        check("lg_rd_wait_G1", 32'(ioctl_wait), 32'd1);
        @(negedge clk_sys);
        check("lg_rd_din_G2", 32'(ioctl_din), 32'({4'h0, init_val(7)}));
        check("lg_rd_wait_G2", 32'(ioctl_wait), 32'd0);
        check("lg_rd_nowe", 32'(we_cnt), 32'(w0));
        end_session(1'b0);

        // Full upload clears dirty
        cpu_pulse();
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int a = 0; a < 1024; a++)
            rd_op(25'(a), 1'b1);
        @(negedge clk_sys);
        check("dirty_pre_end", 32'(nv_dirty), 32'd1);
        end_session(1'b0);
        @(negedge clk_sys);
        check("full_up_clear", 32'(nv_dirty), 32'd0);

        // Full upload with CPU write in the clearing cycle
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int a = 0; a < 1024; a++)
            rd_op(25'(a), 1'b1);
        end_session(1'b1);
        @(negedge clk_sys);
        check("set_wins", 32'(nv_dirty), 32'd1);

        // Reset asserted while in RD
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        @(posedge clk_sys); #1;
        ioctl_addr = 25'd9;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        #2;
        check("pre_rst_state", 32'(dut.state), 32'd2);
        reset_n = 1'b0;
        #1;
        check("mr_din", 32'(ioctl_din), 32'h00);
        check("mr_wait", 32'(ioctl_wait), 32'd0);
        check("mr_req", 32'(nv_req), 32'd0);
        check("mr_addr", 32'(nv_addr), 32'd0);
        check("mr_d", 32'(nv_d), 32'd0);
        check("mr_we", 32'(nv_we), 32'd0);
        check("mr_dirty", 32'(nv_dirty), 32'd0);
        check("mr_state", 32'(dut.state), 32'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        rd_op(25'd9, 1'b1);
        end_session(1'b0);

        repeat (3) @(negedge clk_sys);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nvram_io.md
# nvram_io

Bridges the MiSTer ioctl channel to the game's battery-backed CMOS RAM (high-score/settings NVRAM) so it can be saved and restored.
- **Upload (HPS reads core):** the block services `ioctl_rd` strobes by fetching NVRAM nibbles and returning them on `ioctl_din`.
- **Download (HPS writes core):** it writes received bytes back into NVRAM.
- **Placement:** it sits in the emu top level, beside the ROM download path.
- **Bus access:** it gains the NVRAM port by request/grant against the CPU side.

## Interface
Parameters:
- `ADDR_W`, 10: NVRAM address width (1K locations).
- `DATA_W`, 4: NVRAM data width (≤8).
- `NV_INDEX`, 16'd4: `ioctl_index` value owned by this block.
- `RD_LAT`, 1: NVRAM read latency in cycles (1..3).

Ports:
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: HPS upload session active.
- `ioctl_download` in 1: HPS download session active.
- `ioctl_index` in 16: session target.
- `ioctl_addr` in 25: byte address of the current strobe.
- `ioctl_rd` in 1: one-cycle read strobe.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_dout` in 8: download data.
- `ioctl_din` out 8: upload data.
- `ioctl_wait` out 1: stall to hps_io.
- `nv_req` out 1: request NVRAM port (core holds CPU off NVRAM).
- `nv_gnt` in 1: port granted.
- `nv_addr` out ADDR_W: NVRAM address.
- `nv_q` in DATA_W: NVRAM read data.
- `nv_d` out DATA_W: NVRAM write data.
- `nv_we` out 1: NVRAM write enable.
- `cpu_nv_we` in 1: CPU wrote NVRAM (for dirty tracking).
- `nv_dirty` out 1: NVRAM changed since last complete upload.

## Operation
- **Session:** `sess = (ioctl_upload | ioctl_download) & (ioctl_index == NV_INDEX)`.
  - `nv_req` is registered: it follows `sess` with one cycle delay.
  - It is held for the whole session and drops the cycle after `sess` falls.
- **Strobes:** `ioctl_rd` counts only in an upload session; `ioctl_wr` only in a download session. All other strobes are ignored with no output change.
- **FSM states:** `IDLE`, `WAIT_GNT`, `RD`, `WR`.
  - **`IDLE`:**
    - An accepted strobe latches address and data.
    - Go to `WAIT_GNT` if `nv_gnt`=0.
    - Otherwise go to `RD` (for a read) or `WR` (for a write).
  - **`WAIT_GNT`:** stay until `nv_gnt`=1, then go to `RD` or `WR`.
  - **`RD`:**
    - `nv_addr` is driven; a latency counter runs `RD_LAT` cycles.
    - On expiry: `ioctl_din <= {(8-DATA_W){1'b0}, nv_q}`, then go to `IDLE`.
  - **`WR`:**
    - `nv_we`=1 for exactly one cycle, with `nv_d = ioctl_dout[DATA_W-1:0]`.
    - Upper bits of `ioctl_dout` are discarded. Go to `IDLE`.
- **`ioctl_wait` rule:** `ioctl_wait = ioctl_rd_accepted | ioctl_wr_accepted | (state != IDLE)`.
  - The accepted-strobe term is combinational, so wait rises in the strobe cycle.
  - Wait falls in the cycle `ioctl_din` is valid (read) or the cycle after `nv_we` (write).
- **Out-of-range addresses:** if `ioctl_addr >= 2**ADDR_W`, no NVRAM access is made.
  - A read returns 8'h00 one cycle after the strobe.
  - A write is dropped.
- **Dirty tracking:**
  - `nv_dirty` is set by `cpu_nv_we`.
  - It is cleared when an upload session ends after the strobe at address `2**ADDR_W-1` completed.
  - A completed download session also clears it.
  - If set and clear coincide, set wins.
- **Session ends mid-access:** the in-flight access completes. A read is still captured; a write is still issued. `nv_req` stays up until the FSM returns to `IDLE`.
- **Grant loss:** if `nv_gnt` falls in `RD` or `WR`, the access is restarted from `WAIT_GNT` and no write is issued.

## Timing
- **Reset values:**
  - `ioctl_din`=8'h00, `ioctl_wait`=0, `nv_req`=0, `nv_addr`=0, `nv_d`=0, `nv_we`=0, `nv_dirty`=0.
  - FSM in `IDLE`.
  - Assertion mid-operation aborts immediately, with no write issued.
- **Read latency with grant held:**
  - Strobe at cycle T.
  - `nv_addr` valid at T+1.
  - `ioctl_din` valid and `ioctl_wait`=0 at T+1+RD_LAT.
- **Write with grant held:** strobe at T; `nv_we`=1 at T+1 only; `ioctl_wait`=0 at T+2.
- **Strobe spacing:** a new strobe is never expected while `ioctl_wait`=1. If one arrives anyway it is ignored.

## Structure
- **Package `nvram_pkg`:** holds the FSM state enum, the `NV_INDEX` default, and the `nv_din_pad` function (zero-extend `DATA_W` to 8).
- **Module layout:** single module with no sub-module. Session detection, FSM, latency counter and dirty flag are all small, and splitting them adds ports without reuse.

## Test plan
- **Upload read with grant held:** with upload session index 4, `nv_gnt`=1, RAM[0x005]=4'hA and `ioctl_rd` at addr 5, expect `nv_addr`=5 at T+1, `ioctl_din`=8'h0A at T+2, and `ioctl_wait` high over T..T+1.
- **Download write:** with download session, grant held and `ioctl_wr` at addr 0x3FF with data 8'hF7, expect a single `nv_we` pulse at T+1 with `nv_addr`=0x3FF and `nv_d`=4'h7.
- **Late grant:** with grant held low 5 cycles after the strobe, expect `ioctl_wait` to stay high and no `nv_we`. Data appears RD_LAT+1 cycles after `nv_gnt` rises.
- **Filtered strobes:**
  - A wrong index (3) or a 0x400 address: no NVRAM access.
  - An out-of-range read returns 8'h00.
  - `ioctl_wr` during an upload session is ignored.
- **Dirty flag:**
  - `cpu_nv_we` sets `nv_dirty`.
  - A full 1024-byte upload clears it.
  - `cpu_nv_we` in the clearing cycle leaves it set.
- **Reset mid-read:** drop `reset_n` in `RD`. Expect all outputs at reset values asynchronously and FSM `IDLE`. After release, a fresh read works.
